// File: rtl/mdu_wb.sv
// Iterative RV32M multiply/divide unit writing its result to the register file.
// Optional MDU_FAST_PATH_EN: divide-by-zero, signed overflow and rd=0 ops bypass CALC.
module mdu_wb #(
    parameter int unsigned XLEN = 32
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic            rf_we,
    output logic [4:0]      wR,
    output logic [XLEN-1:0] wD
);

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;
    logic [4:0]        wr_q, wr_d;
    logic [XLEN-1:0]   wd_q, wd_d;

    logic              neg1, neg2, in_dz, in_ovf;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN-1:0]   rem_nx, quo_nx, quo_s, rem_s, res;
    logic              ge;

    always_comb begin
        neg1   = (op inside {OpMulh, OpMulhsu, OpDiv, OpRem}) && src1[XLEN-1];
        neg2   = (op inside {OpMulh, OpDiv, OpRem}) && src2[XLEN-1];
        mag1   = neg1 ? -src1 : src1;
        mag2   = neg2 ? -src2 : src2;
        in_dz  = op[2] && (src2 == '0);
        in_ovf = (op inside {OpDiv, OpRem}) && (src1 == MinNeg) && (src2 == AllOnes);
    end

    // One shift-add step and one restoring-division step; only the one matching op_q is kept.
    always_comb begin
        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        acc_nx = {sum, acc_q[XLEN-1:1]};
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, opa_q};
        ge     = ~diff[XLEN];
        rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], ge};
        prod   = negq_q ? -acc_nx : acc_nx;
        quo_s  = negq_q ? -quo_nx : quo_nx;
        rem_s  = negr_q ? -rem_nx : rem_nx;
        case (op_q)
            OpMul:                      res = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  res = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              res = dz_q ? AllOnes : (ovf_q ? MinNeg : quo_s);
            default:                    res = ovf_q ? '0 : rem_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opa_d   = opa_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        wr_d    = wr_q;
        wd_d    = wd_q;
        case (state_q)
            StIdle: begin
                if (start && !kill) begin
                    state_d = StCalc;
                    cnt_d   = '0;
                    op_d    = op;
                    rd_d    = rd;
                    // Divide keeps the divisor in opa, multiply keeps the multiplicand there.
                    opa_d   = op[2] ? mag2 : mag1;
                    acc_d   = {{XLEN{1'b0}}, mag2};
                    rem_d   = '0;
                    quo_d   = mag1;
                    negq_d  = neg1 ^ neg2;
                    negr_d  = neg1;
                    dz_d    = in_dz;
                    ovf_d   = in_ovf;
`ifdef MDU_FAST_PATH_EN
                    if (in_dz || in_ovf || (rd == '0)) begin
                        state_d = StDone;
                        wr_d    = rd;
                        // x0 results are discarded, so wD is left as is for rd=0.
                        if (in_dz || in_ovf) begin
                            wd_d = op[1] ? (in_ovf ? '0 : src1) : (in_dz ? AllOnes : MinNeg);
                        end
                    end
`endif
                end
            end
            StCalc: begin
                if (kill) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    acc_d = acc_nx;
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q == 5'd31) begin
                        state_d = StDone;
                        wr_d    = rd_q;
                        wd_d    = res;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            opa_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opa_q   <= opa_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);
    assign rf_we = done && (wr_q != '0);
    assign wR    = wr_q;
    assign wD    = wd_q;

endmodule

// File: tb/tb_mdu_wb.sv
// Scoreboard bench for mdu_wb: random and directed RV32M ops against a 64-bit arithmetic model.
module tb_mdu_wb;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  rd = '0;
    logic        busy, done, rf_we;
    logic [4:0]  wR;
    logic [31:0] wD;

    mdu_wb #(.XLEN(32)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .start     (start),
        .kill      (kill),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
        .rf_we     (rf_we),
        .wR        (wR),
        .wD        (wD)
    );

    always #5 cpu_clk = ~cpu_clk;

    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wd;
        logic        chk_wd;
        int          due;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p[63:32];
            end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] r);
`ifdef MDU_FAST_PATH_EN
        if ((r == 0) || (o[2] && b == 0) ||
            (!o[0] && o[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    always @(negedge cpu_clk) begin
        if (cpu_rst_n) begin
            chk("rf_we_outside_done", {63'b0, rf_we & ~done}, 64'd0);
            if (done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 wR=%0d wD=0x%0h, expected none",
                             wR, wD);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.due));
                    chk("wR", {59'b0, wR}, {59'b0, e.rd});
                    chk("rf_we", {63'b0, rf_we}, {63'b0, e.we});
                    if (e.chk_wd) chk("wD", {32'b0, wD}, {32'b0, e.wd});
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r);
        exp_t e;
        int   lat;
        @(posedge cpu_clk); #1;
        kill = 1'b0;
        chk("busy_idle", {63'b0, busy}, 64'd0);
        lat      = latency(o, a, b, r);
        e.rd     = r;
        e.we     = (r != 0);
        e.wd     = ref_res(o, a, b);
        e.chk_wd = (lat == 33) || (r != 0);
        e.due    = cyc + lat;
        q.push_back(e);
        start = 1'b1; op = o; src1 = a; src2 = b; rd = r;
        for (int k = 1; k <= lat; k++) begin
            @(posedge cpu_clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                start = 1'b1;
                op    = 3'($urandom);
                src1  = $urandom;
                src2  = $urandom;
                rd    = 5'($urandom);
            end
            if (k == 6) start = 1'b0;
            @(negedge cpu_clk);
            chk("busy_calc", {63'b0, busy}, 64'd1);
        end
    endtask

    task automatic kill_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input int kat);
        @(posedge cpu_clk); #1;
        start = 1'b1; op = o; src1 = a; src2 = b; rd = r;
        for (int k = 1; k <= kat; k++) begin
            @(posedge cpu_clk); #1;
            if (k == 1) start = 1'b0;
            if (k == kat) kill = 1'b1;
            @(negedge cpu_clk);
            chk("busy_before_kill", {63'b0, busy}, 64'd1);
        end
    endtask

    task automatic rst_op(input int rat);
        @(posedge cpu_clk); #1;
        start = 1'b1; op = 3'd0; src1 = 32'h1234_5678; src2 = 32'h9; rd = 5'd7;
        for (int k = 1; k <= rat; k++) begin
            @(posedge cpu_clk); #1;
            if (k == 1) start = 1'b0;
            if (k == rat) cpu_rst_n = 1'b0;
        end
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_done", {63'b0, done}, 64'd0);
        chk("mid_rst_rf_we", {63'b0, rf_we}, 64'd0);
        chk("mid_rst_wR", {59'b0, wR}, 64'd0);
        chk("mid_rst_wD", {32'b0, wD}, 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_rf_we", {63'b0, rf_we}, 64'd0);
        chk("rst_wR", {59'b0, wR}, 64'd0);
        chk("rst_wD", {32'b0, wD}, 64'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9);
        run_op(3'd5, 32'h1234, 32'd0, 5'd10);
        run_op(3'd7, 32'h1234, 32'd0, 5'd11);
        run_op(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd12);
        run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd13);
        run_op(3'd0, 32'd12345, 32'd678, 5'd0);

        kill_op(3'd4, 32'd1000, 32'd7, 5'd14, 10);
        run_op(3'd4, 32'd1000, 32'd7, 5'd15);
        rst_op(20);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd16);

        for (int i = 0; i < 200; i++) begin
            run_op(3'($urandom), rnd_operand(), rnd_operand(), 5'($urandom));
        end

        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_wb.md
Name: mdu_wb

Overview:
- Iterative RV32M multiply/divide unit that drives the register-file write port (rf_we/wR/wD) at writeback.
- Accepts one operation from decode/execute, using rD1/rD2 from the register file plus the destination rd.
- Computes over multiple cycles, then presents a single-cycle write to the register file.
- Decode stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- cpu_clk  input  1  clock; all state updates on the rising edge.
- cpu_rst_n  input  1  reset, synchronous, active-low.
- start  input  1  operation request; sampled only in IDLE.
- kill  input  1  pipeline flush; abandons any in-flight operation.
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  input  32  rs1 value (dividend / multiplicand).
- src2  input  32  rs2 value (divisor / multiplier).
- rd  input  5  destination register index.
- busy  output  1  operation accepted and not yet retired.
- done  output  1  one-cycle pulse when the result is presented.
- rf_we  output  1  register-file write enable.
- wR  output  5  register-file write index.
- wD  output  32  register-file write data.

Behaviour:
- Clock/reset: one clock cpu_clk; reset cpu_rst_n is synchronous, active-low.
- Reset (cpu_rst_n=0 at a rising edge): state=IDLE; busy, done, rf_we = 0; wR = 0; wD = 0; counter and datapath registers cleared.
- Reset mid-operation: same as above; no write is ever issued for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and kill=0 at an edge → latch op, rd, |src1|, |src2| (magnitudes taken for signed ops), result-sign flags, counter=0 → CALC.
  - Otherwise stay in IDLE.
- CALC:
  - One iteration per cycle; 32 iterations with counter 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division, 32-bit quotient and 33-bit partial remainder.
  - When counter=31 → DONE.
- DONE (exactly one cycle):
  - done=1; rf_we = (rd != 0); wR = latched rd; wD = result.
  - Next state IDLE.
- Latency:
  - start high in cycle 0 → CALC in cycles 1..32 → DONE in cycle 33.
  - busy=1 in cycles 1..33.
  - Back-to-back: the next start is accepted in cycle 34 (IDLE) at the earliest.
- Busy rules:
  - start while busy=1 is ignored; no queueing.
  - Inputs other than kill/reset are don't-care while busy.
- Result selection:
  - MUL: product[31:0].
  - MULH: signed×signed, product[63:32].
  - MULHSU: signed src1 × unsigned src2, product[63:32].
  - MULHU: unsigned×unsigned, product[63:32].
  - Signed products are negated as 64-bit two's complement when the operand signs differ.
- Divide signs:
  - Quotient sign = sign(src1) XOR sign(src2).
  - Remainder sign = sign(src1).
- Divide by zero (src2=0):
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → src1 unchanged.
- Signed overflow (DIV/REM with src1=0x80000000, src2=0xFFFFFFFF):
  - DIV → 0x80000000.
  - REM → 0x00000000.
- rd=0: done still pulses, rf_we stays 0, so x0 is never written.
- kill:
  - When kill=1 at an edge in CALC or DONE → IDLE; done and rf_we are 0 from the next cycle on.
  - kill in DONE suppresses nothing already visible in that cycle; the write in that cycle still occurs.
  - kill takes priority over start in IDLE.
- Outputs are registered.
  - wR/wD hold their last values outside DONE.
  - rf_we and done are 0 outside DONE.

Optional Feature:
- Macro MDU_FAST_PATH_EN.
- Defined: divide-by-zero, signed overflow and rd=0 ops skip CALC (IDLE → DONE directly).
  - DONE is in cycle 1; busy=1 for cycle 1 only.
  - Result values are identical to those specified above.
- Undefined: every operation takes the full 33-cycle path; special-case results are forced in DONE.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD, rd=5 → cycle 33: done=1, rf_we=1, wR=5, wD=0xFFFFFFEB; busy high cycles 1..33.
- MULHU src1=src2=0xFFFFFFFF → wD=0xFFFFFFFE; MULH same operands → wD=0x00000000; MULHSU src1=0xFFFFFFFF, src2=2 → wD=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → wD=0x80000000; REM same → 0; DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF.
- DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. DONE in cycle 33 without MDU_FAST_PATH_EN, cycle 1 with it.
- MUL with rd=0 → done pulses, rf_we=0. Second start asserted in cycle 5 → ignored, only one done seen.
- kill at cycle 10 of a DIV → busy=0 from cycle 11, no done/rf_we. New start in cycle 11 → completes at cycle 44. cpu_rst_n=0 at cycle 20 of a MUL → all outputs 0 next cycle, no write.
